ub_write_packer: RTL and testbench

Downstream neighbour of the activation pipeline. Consumes its quantized int8 stream (`valid_out`/`ub_data_out`) and packs four consecutive bytes into one 32-bit word with a byte mask. Writes each word into the unified buffer over a valid/ready write port, using a small word FIFO to absorb UB backpressure. A start/done control runs one transfer of a programmed byte count to a programmed base address.

---
 rtl/ub_write_packer_if.sv | 34 +++
 rtl/ub_write_packer.sv | 192 +++++++++++++++++++
 tb/tb_ub_write_packer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ub_write_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ub_write_packer_if
//  Brief    : Unified-buffer word write port (valid/ready, address, data, mask)
//  Revision : 1.0 - initial release
// ============================================================================
interface ub_write_packer_if #(
    parameter int ADDR_W = 8
);
    logic              ub_wr_valid;
    logic              ub_wr_ready;
    logic [ADDR_W-1:0] ub_wr_addr;
    logic [31:0]       ub_wr_data;
    logic [3:0]        ub_wr_mask;

    // Packer side: issues write requests, observes acceptance
    modport master (
        output ub_wr_valid,
        output ub_wr_addr,
        output ub_wr_data,
        output ub_wr_mask,
        input  ub_wr_ready
    );

    // Unified-buffer side: accepts write requests
    modport slave (
        input  ub_wr_valid,
        input  ub_wr_addr,
        input  ub_wr_data,
        input  ub_wr_mask,
        output ub_wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/ub_write_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ub_write_packer
//  Brief    : Packs an int8 byte stream into masked 32-bit words and writes
//             them to the unified buffer through a small word FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module ub_write_packer #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [15:0]       byte_count,
    input  wire logic              valid_in,
    input  wire logic [7:0]        data_in,
    ub_write_packer_if.master      ub,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  c_FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_remaining;
    logic [1:0]         r_lane;
    logic [31:0]        r_word;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [3:0]         r_fifo_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_byte;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_drop;
    logic [31:0]        w_word;
    logic [3:0]         w_push_mask;

    // Byte acceptance, word completion and FIFO handshake decode
    always_comb begin
        w_byte      = (r_state == S_PACK) && valid_in;
        w_last      = (r_remaining == 16'd1);
        w_push      = w_byte && ((r_lane == 2'd3) || w_last);
        w_empty     = (r_count == '0);
        w_full      = (r_count == c_FIFO_FULL);
        w_pop       = !w_empty && ub.ub_wr_ready;
        // A full FIFO still takes a word when the head leaves in the same cycle
        w_push_ok   = w_push && (!w_full || w_pop);
        w_drop      = w_push && w_full && !w_pop;
        // Lanes at and above r_lane are held at zero, so OR-in is a lane write
        w_word      = r_word | ({24'd0, data_in} << {r_lane, 3'b000});
        w_push_mask = 4'b1111 >> (2'd3 - r_lane);
    end

    // Transfer control: state, address/byte counters, partial word, busy/done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_word      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= byte_count;
                        r_lane      <= '0;
                        r_word      <= '0;
                        r_busy      <= 1'b1;
                        if (byte_count == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PACK;
                        end
                    end
                end
                S_PACK: begin
                    if (w_byte) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (w_push) begin
                            // Address advances even when the word is dropped
                            r_addr <= r_addr + 1'b1;
                            r_lane <= '0;
                            r_word <= '0;
                        end else begin
                            r_lane <= r_lane + 2'd1;
                            r_word <= w_word;
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Word FIFO storage and occupancy; entries reset so the head reads zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_mask[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_fifo_addr[r_wr_ptr] <= r_addr;
                r_fifo_data[r_wr_ptr] <= w_word;
                r_fifo_mask[r_wr_ptr] <= w_push_mask;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ub.ub_wr_valid = !w_empty;
    assign ub.ub_wr_addr  = r_fifo_addr[r_rd_ptr];
    assign ub.ub_wr_data  = r_fifo_data[r_rd_ptr];
    assign ub.ub_wr_mask  = r_fifo_mask[r_rd_ptr];

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ub_write_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ub_write_packer
//  Brief    : Directed self-checking bench for ub_write_packer
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ub_write_packer;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       byte_count;
    logic              valid_in;
    logic [7:0]        data_in;
    logic              busy;
    logic              done;
    logic              overflow;

    ub_write_packer_if #(.ADDR_W(ADDR_W)) ub ();

    ub_write_packer #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ub         (ub.master),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          tests     = 0;
    int          failed    = 0;
    int          done_cnt  = 0;
    int          valid_cnt = 0;
    logic [43:0] wq[$];

    // Record accepted writes, done pulses and valid cycles mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (ub.ub_wr_valid && ub.ub_wr_ready) wq.push_back({ub.ub_wr_addr, ub.ub_wr_data, ub.ub_wr_mask});
            if (done) done_cnt++;
            if (ub.ub_wr_valid) valid_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        logic [43:0] got;
        got = (idx < wq.size()) ? wq[idx] : 44'bx;
        check(tag, {20'd0, got}, {20'd0, a, d, m});
    endtask

    task automatic check_head(input string tag, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] m);
        check(tag, {19'd0, ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, ub.ub_wr_mask},
                   {19'd0, 1'b1, a, d, m});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {16'd0, ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, ub.ub_wr_mask,
                    busy, done, overflow}, 64'd0);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [15:0] c);
        start      = 1'b1;
        base_addr  = b;
        byte_count = c;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        valid_in = 1'b1;
        data_in  = b;
        tick();
        valid_in = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        base_addr      = '0;
        byte_count     = '0;
        valid_in       = 1'b0;
        data_in        = '0;
        ub.ub_wr_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        reset_n = 1'b1;
        tick();

        // Eight bytes back-to-back, ready high
        clear_log();
        ub.ub_wr_ready = 1'b1;
        do_start(8'h10, 16'd8);
        check("t1_busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 0);
            if (i == 4) check("t1_push_latency", {63'd0, ub.ub_wr_valid}, 64'd1);
        end
        wait_idle("t1_timeout", 50);
        check("t1_nwrites", wq.size(), 2);
        check_wr("t1_w0", 0, 8'h10, 32'h04030201, 4'hF);
        check_wr("t1_w1", 1, 8'h11, 32'h08070605, 4'hF);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_overflow", {63'd0, overflow}, 64'd0);

        // Six bytes with one idle cycle between each
        clear_log();
        do_start(8'h10, 16'd6);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
        wait_idle("t2_timeout", 50);
        check("t2_nwrites", wq.size(), 2);
        check_wr("t2_w0", 0, 8'h10, 32'h04030201, 4'hF);
        check_wr("t2_w1", 1, 8'h11, 32'h00000605, 4'h3);

        // 24 bytes against a stalled UB: words 5 and 6 are dropped
        clear_log();
        ub.ub_wr_ready = 1'b0;
        do_start(8'h00, 16'd24);
        for (int i = 1; i <= 24; i++) send_byte(8'(i), 0);
        tick();
        check("t3_overflow_set", {63'd0, overflow}, 64'd1);
        check("t3_busy_while_stalled", {63'd0, busy}, 64'd1);
        check("t3_no_done_while_stalled", done_cnt, 0);
        ub.ub_wr_ready = 1'b1;
        wait_idle("t3_timeout", 50);
        check("t3_nwrites", wq.size(), 4);
        check_wr("t3_w0", 0, 8'h00, 32'h04030201, 4'hF);
        check_wr("t3_w1", 1, 8'h01, 32'h08070605, 4'hF);
        check_wr("t3_w2", 2, 8'h02, 32'h0C0B0A09, 4'hF);
        check_wr("t3_w3", 3, 8'h03, 32'h100F0E0D, 4'hF);
        check("t3_done_pulses", done_cnt, 1);
        tick();
        check("t3_overflow_sticky", {63'd0, overflow}, 64'd1);

        // Zero-length transfer, plus a start while busy
        clear_log();
        do_start(8'h40, 16'd0);
        check("t4_done_next_cycle", {62'd0, busy, done}, 64'd3);
        check("t4_overflow_cleared", {63'd0, overflow}, 64'd0);
        start      = 1'b1;
        base_addr  = 8'h30;
        byte_count = 16'd4;
        tick();
        start = 1'b0;
        check("t4_start_in_done_ignored", {62'd0, busy, done}, 64'd0);
        repeat (3) tick();
        check("t4_still_idle", {63'd0, busy}, 64'd0);
        check("t4_no_valid", valid_cnt, 0);
        check("t4_done_pulses", done_cnt, 1);

        // Address wrap at 0xFF and head stability under backpressure
        clear_log();
        ub.ub_wr_ready = 1'b0;
        do_start(8'hFF, 16'd8);
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin
                start      = 1'b1;
                base_addr  = 8'h55;
                byte_count = 16'd2;
            end
            send_byte(8'(i), 0);
            start = 1'b0;
        end
        check_head("t5_head0", 8'hFF, 32'h04030201, 4'hF);
        repeat (3) tick();
        check_head("t5_head0_stable", 8'hFF, 32'h04030201, 4'hF);
        ub.ub_wr_ready = 1'b1;
        tick();
        ub.ub_wr_ready = 1'b0;
        check_head("t5_head1", 8'h00, 32'h08070605, 4'hF);
        repeat (2) tick();
        check_head("t5_head1_stable", 8'h00, 32'h08070605, 4'hF);
        ub.ub_wr_ready = 1'b1;
        wait_idle("t5_timeout", 50);
        check("t5_nwrites", wq.size(), 2);
        check_wr("t5_w0", 0, 8'hFF, 32'h04030201, 4'hF);
        check_wr("t5_w1", 1, 8'h00, 32'h08070605, 4'hF);
        check("t5_done_pulses", done_cnt, 1);

        // Asynchronous reset in the middle of a word
        clear_log();
        do_start(8'h40, 16'd8);
        for (int i = 1; i <= 3; i++) send_byte(8'hB0 + 8'(i), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t6_no_partial_word", {32'd0, valid_cnt}, 64'd0);
        check("t6_idle_after_reset", {63'd0, busy}, 64'd0);
        do_start(8'h20, 16'd4);
        for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i), 0);
        wait_idle("t6_timeout", 50);
        check("t6_nwrites", wq.size(), 1);
        check_wr("t6_w0", 0, 8'h20, 32'hA4A3A2A1, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
